// File: rtl/uart_rx_oversample.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_oversample
// Purpose  : UART receive front end for 8N1, LSB-first, idle-high serial
//            lines. Provides a two-flop input synchronizer, a three-sample
//            majority vote, rejection of false start bits and a framing-error
//            report. Each good byte is presented together with a one-cycle
//            strobe that can drive a FIFO write enable directly.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_oversample #(
  parameter int WAIT_DIV = 868              // clocks per bit, must be >= 8
) (
  input  logic       clk,
  input  logic       rst,                   // asynchronous, active high
  input  logic       data_in,               // raw serial line
  output logic [7:0] data_out,              // last good byte received
  output logic       ren,                   // data_out valid strobe
  output logic       busy,                  // frame in progress
  output logic       frame_err              // stop bit sampled low strobe
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // The counter reads 0 in the first cycle after the start edge is seen, so a
  // bit centre (edge + WAIT_DIV/2 cycles) lines up with count WAIT_DIV/2 - 1.
  localparam logic [15:0] C_SAMPLE_CNT = 16'(WAIT_DIV / 2 - 1);
  localparam logic [15:0] C_LAST_CNT   = 16'(WAIT_DIV - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic        sync_meta;                   // first synchronizer stage
  logic        rx_s;                        // synchronized line
  logic        rx_d1;                       // rx_s delayed one cycle
  logic        rx_d2;                       // rx_s delayed two cycles
  logic        bit_val;                     // majority of the three samples
  logic        sample_pt;                   // this cycle is a bit centre

  logic [2:0]  state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  // --------------------------------------------------------------------------
  // Input synchronizer and sample history; reset to the idle (high) level so
  // that leaving reset never looks like a start edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
      rx_d1     <= 1'b1;
      rx_d2     <= 1'b1;
    end else begin
      sync_meta <= data_in;
      rx_s      <= sync_meta;
      rx_d1     <= rx_s;
      rx_d2     <= rx_d1;
    end
  end

  // Majority vote over the current and two previous samples masks a single
  // cycle of noise at the bit centre.
  assign bit_val   = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
  assign sample_pt = (bit_cnt == C_SAMPLE_CNT);

  // Busy covers every state of a frame, including the break wait.
  assign busy      = (state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Bit-period counter: held at zero while idle or waiting out a break, and
  // free-running modulo WAIT_DIV while a frame is being sampled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 16'd0;
    end else if ((state == ST_IDLE) || (state == ST_BREAK)) begin
      bit_cnt <= 16'd0;
    end else if (bit_cnt == C_LAST_CNT) begin
      bit_cnt <= 16'd0;
    end else begin
      bit_cnt <= bit_cnt + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame state machine, data shift register and output strobes. The strobes
  // default low every cycle so each one lasts exactly a single clock.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      data_out  <= 8'd0;
      ren       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ren       <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // First low synchronized sample marks the candidate start edge.
          if (!rx_s) begin
            state <= ST_START;
          end
        end

        ST_START: begin
          // A line that is high again mid start bit was only a glitch.
          if (sample_pt) begin
            if (bit_val) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= 3'd0;
            end
          end
        end

        ST_DATA: begin
          // LSB arrives first, so shift right and insert at the top.
          if (sample_pt) begin
            shreg <= {bit_val, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        ST_STOP: begin
          // Returning to idle at the stop-bit centre lets a back-to-back
          // frame's start edge be caught without loss.
          if (sample_pt) begin
            if (bit_val) begin
              data_out <= shreg;
              ren      <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end
        end

        ST_BREAK: begin
          // Wait for the line to recover; a low line here is not a start.
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversample.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_oversample
// Purpose  : Self-checking bench for uart_rx_oversample with a frame-level
//            reference model working on the per-clock line waveform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversample;

  localparam int WD   = 16;
  localparam int H    = WD / 2;
  localparam int MAXL = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic [7:0] data_out;
  logic       ren;
  logic       busy;
  logic       frame_err;

  uart_rx_oversample #(.WAIT_DIV(WD)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_out  (data_out),
    .ren       (ren),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Line waveform, one entry per clock.
  logic ln [MAXL];
  int   nl;

  // Reference-model results.
  int         exp_ren_cyc[$];
  logic [7:0] exp_ren_dat[$];
  int         exp_fe_cyc[$];
  logic       exp_busy [MAXL+1];
  logic [7:0] model_last;

  // Observed results.
  int         got_ren_cyc[$];
  logic [7:0] got_ren_dat[$];
  int         got_fe_cyc[$];
  int         got_busy_cycles;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         nfr;
    logic       stopb;
    int         glitch_k;
    logic [7:0] exp_data;
    int         exp_ren;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic append_bits(input logic v, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (nl < MAXL) begin
        ln[nl] = v;
        nl++;
      end
    end
  endtask

  task automatic append_frame(input logic [7:0] b, input logic stopb);
    append_bits(1'b0, WD);
    for (int k = 0; k < 8; k++) append_bits(b[k], WD);
    append_bits(stopb, WD);
  endtask

  // Synchronized line as seen in cycle c: the pad value two clocks earlier.
  function automatic logic rxs(input int c);
    if (c - 2 >= 0 && c - 2 < nl) return ln[c-2];
    return 1'b1;
  endfunction

  function automatic logic maj(input int c);
    int s;
    s = int'(rxs(c)) + int'(rxs(c-1)) + int'(rxs(c-2));
    return (s >= 2);
  endfunction

  task automatic mark(input int a, input int b);
    for (int i = a; i <= b; i++) if (i <= nl) exp_busy[i] = 1'b1;
  endtask

  // Frame-level model: find start edges, evaluate the ten bit centres.
  task automatic model_run();
    int c, t0, s0, s9, cb;
    logic [7:0] d;
    exp_ren_cyc.delete();
    exp_ren_dat.delete();
    exp_fe_cyc.delete();
    for (int i = 0; i <= nl; i++) exp_busy[i] = 1'b0;
    c = 1;
    while (c <= nl) begin
      if (rxs(c) == 1'b0) begin
        t0 = c;
        s0 = t0 + H;
        if (s0 > nl) break;
        if (maj(s0)) begin
          mark(t0 + 1, s0);
          c = s0 + 1;
        end else begin
          s9 = s0 + 9 * WD;
          if (s9 + 1 > nl) break;
          d = 8'd0;
          for (int k = 1; k <= 8; k++) d[k-1] = maj(s0 + k * WD);
          if (maj(s9)) begin
            mark(t0 + 1, s9);
            exp_ren_cyc.push_back(s9 + 1);
            exp_ren_dat.push_back(d);
            model_last = d;
            c = s9 + 1;
          end else begin
            exp_fe_cyc.push_back(s9 + 1);
            cb = s9 + 1;
            while (cb <= nl && rxs(cb) == 1'b0) cb++;
            mark(t0 + 1, cb);
            c = cb + 1;
          end
        end
      end else begin
        c++;
      end
    end
  endtask

  // Drive the waveform and compare against the model.
  task automatic drive_run(input string tag);
    int c, bm, both, m;
    model_run();
    got_ren_cyc.delete();
    got_ren_dat.delete();
    got_fe_cyc.delete();
    got_busy_cycles = 0;
    bm = 0;
    both = 0;
    for (int i = 0; i < nl; i++) begin
      data_in = ln[i];
      @(posedge clk);
      #1;
      c = i + 1;
      if (ren === 1'b1) begin
        got_ren_cyc.push_back(c);
        got_ren_dat.push_back(data_out);
      end
      if (frame_err === 1'b1) got_fe_cyc.push_back(c);
      if (ren === 1'b1 && frame_err === 1'b1) both++;
      if (busy === 1'b1) got_busy_cycles++;
      if (busy !== exp_busy[c]) bm++;
    end
    check({tag, " ren_count"}, got_ren_cyc.size(), exp_ren_cyc.size());
    m = (got_ren_cyc.size() < exp_ren_cyc.size()) ? got_ren_cyc.size() : exp_ren_cyc.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s ren_cycle[%0d]", tag, i), got_ren_cyc[i], exp_ren_cyc[i]);
      check($sformatf("%s ren_data[%0d]", tag, i), {24'd0, got_ren_dat[i]}, {24'd0, exp_ren_dat[i]});
    end
    check({tag, " ferr_count"}, got_fe_cyc.size(), exp_fe_cyc.size());
    m = (got_fe_cyc.size() < exp_fe_cyc.size()) ? got_fe_cyc.size() : exp_fe_cyc.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s ferr_cycle[%0d]", tag, i), got_fe_cyc[i], exp_fe_cyc[i]);
    check({tag, " busy_mismatch_cycles"}, bm, 0);
    check({tag, " ren_and_ferr_together"}, both, 0);
    check({tag, " data_out_final"}, {24'd0, data_out}, {24'd0, model_last});
  endtask

  initial begin
    int fs, gi, lim;
    logic [7:0] b;
    logic sb;

    vecs[0] = '{8'h55, 8'h00, 1, 1'b1, -1, 8'h55, 1, 0};
    vecs[1] = '{8'hA3, 8'h0F, 2, 1'b1, -1, 8'h0F, 2, 0};
    vecs[2] = '{8'h3C, 8'h00, 1, 1'b1,  3, 8'h3C, 1, 0};
    vecs[3] = '{8'h00, 8'h00, 1, 1'b0, -1, 8'h3C, 0, 1};
    vecs[4] = '{8'h01, 8'hFE, 2, 1'b1,  7, 8'hFE, 2, 0};
    vecs[5] = '{8'hFF, 8'h80, 2, 1'b1,  9, 8'h80, 2, 0};

    // Reset state.
    rst = 1'b1;
    data_in = 1'b1;
    model_last = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset data_out", {24'd0, data_out}, 32'd0);
    check("reset ren", {31'd0, ren}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed frame table.
    for (int v = 0; v < 6; v++) begin
      nl = 0;
      append_bits(1'b1, 8);
      fs = nl;
      if (vecs[v].nfr == 2) begin
        append_frame(vecs[v].b0, 1'b1);
        append_frame(vecs[v].b1, vecs[v].stopb);
      end else begin
        append_frame(vecs[v].b0, vecs[v].stopb);
      end
      if (!vecs[v].stopb) append_bits(1'b0, 40);
      append_bits(1'b1, 3 * WD);
      if (vecs[v].glitch_k >= 0) begin
        gi = fs + H + vecs[v].glitch_k * WD;
        ln[gi] = ~ln[gi];
      end
      drive_run($sformatf("vec%0d", v));
      check($sformatf("vec%0d table_ren", v), got_ren_cyc.size(), vecs[v].exp_ren);
      check($sformatf("vec%0d table_ferr", v), got_fe_cyc.size(), vecs[v].exp_fe);
      check($sformatf("vec%0d table_data", v), {24'd0, data_out}, {24'd0, vecs[v].exp_data});
      if (vecs[v].nfr == 2 && got_ren_cyc.size() == 2)
        check($sformatf("vec%0d b2b_spacing", v), got_ren_cyc[1] - got_ren_cyc[0], 10 * WD);
    end

    // False start: line low for 4 clocks.
    nl = 0;
    append_bits(1'b1, 8);
    append_bits(1'b0, 4);
    append_bits(1'b1, 3 * WD);
    drive_run("false_start");
    check("false_start ren", got_ren_cyc.size(), 0);
    check("false_start ferr", got_fe_cyc.size(), 0);
    check("false_start busy_len", got_busy_cycles, H);
    check("false_start data_kept", {24'd0, data_out}, 32'h80);

    // Reset during data bit 4 of 0xFF, then receive 0x81.
    nl = 0;
    append_bits(1'b1, 8);
    append_frame(8'hFF, 1'b1);
    lim = 8 + 2 + H + 5 * WD;
    for (int i = 0; i < lim; i++) begin
      data_in = ln[i];
      @(posedge clk);
      #1;
    end
    check("pre_reset busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset data_out", {24'd0, data_out}, 32'd0);
    check("mid_reset busy", {31'd0, busy}, 32'd0);
    check("mid_reset ren", {31'd0, ren}, 32'd0);
    check("mid_reset frame_err", {31'd0, frame_err}, 32'd0);
    data_in = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_last = 8'd0;
    nl = 0;
    append_bits(1'b1, 8);
    append_frame(8'h81, 1'b1);
    append_bits(1'b1, 3 * WD);
    drive_run("after_reset");
    check("after_reset data", {24'd0, data_out}, 32'h81);

    // Randomized traffic: bytes, gaps, bad stop bits, glitches, false starts.
    nl = 0;
    append_bits(1'b1, 8);
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        append_bits(1'b1, 2);
        append_bits(1'b0, $urandom_range(1, 5));
        append_bits(1'b1, H + 4);
      end
      append_bits(1'b1, $urandom_range(0, 12));
      fs = nl;
      b = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      append_frame(b, sb);
      if (!sb) append_bits(1'b0, $urandom_range(0, 30));
      if ($urandom_range(0, 2) == 0) begin
        gi = fs + $urandom_range(0, 10 * WD - 1);
        ln[gi] = ~ln[gi];
      end
    end
    append_bits(1'b1, 3 * WD);
    drive_run("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
